// File: rtl/coord_bcd_scheduler.sv
// Converts three 10-bit coordinates to 3-digit BCD once per frame using one
// shared double-dabble engine, publishing all channels together.
module coord_bcd_scheduler #(
    parameter bit CLAMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [9:0]  x_coord,
    input  logic [9:0]  y_coord,
    input  logic [9:0]  z_coord,
    output logic [11:0] x_bcd,
    output logic [11:0] y_bcd,
    output logic [11:0] z_bcd,
    output logic [2:0]  sat,
    output logic        done,
    output logic        bcd_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, PUBLISH} state_t;

    state_t      state, state_next;
    logic [1:0]  channel;
    logic [3:0]  shift_cnt;
    logic [9:0]  snap_x, snap_y, snap_z;
    logic [11:0] acc, acc_adj;
    logic [9:0]  bin;
    logic [11:0] pend_x, pend_y, pend_z;
    logic [2:0]  pend_sat;
    logic [9:0]  sel_raw, sel_fixed;
    logic        sel_over;

    assign busy = (state != IDLE);

    always_comb begin
        sel_raw = snap_x;
        case (channel)
            2'd1:    sel_raw = snap_y;
            2'd2:    sel_raw = snap_z;
            default: sel_raw = snap_x;
        endcase
        sel_over  = (sel_raw >= 10'd1000);
        sel_fixed = sel_raw;
        if (sel_over)
            sel_fixed = CLAMP ? 10'd999 : (sel_raw - 10'd1000);
    end

    // Double-dabble correction: any digit of 5 or more would overflow when doubled.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (shift_cnt == 4'd9) state_next = STORE;
            STORE:   state_next = (channel == 2'd2) ? PUBLISH : LOAD;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            channel   <= 2'd0;
            shift_cnt <= 4'd0;
            snap_x    <= '0;
            snap_y    <= '0;
            snap_z    <= '0;
            acc       <= '0;
            bin       <= '0;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_z    <= '0;
            pend_sat  <= '0;
            x_bcd     <= '0;
            y_bcd     <= '0;
            z_bcd     <= '0;
            sat       <= '0;
            done      <= 1'b0;
            bcd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (frame_start && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        snap_x   <= x_coord;
                        snap_y   <= y_coord;
                        snap_z   <= z_coord;
                        channel  <= 2'd0;
                        pend_sat <= 3'b000;
                    end
                end
                LOAD: begin
                    acc       <= '0;
                    bin       <= sel_fixed;
                    shift_cnt <= 4'd0;
                    case (channel)
                        2'd1:    pend_sat[1] <= sel_over;
                        2'd2:    pend_sat[2] <= sel_over;
                        default: pend_sat[0] <= sel_over;
                    endcase
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[10:0], bin, 1'b0};
                    shift_cnt  <= (shift_cnt == 4'd9) ? 4'd0 : shift_cnt + 4'd1;
                end
                STORE: begin
                    case (channel)
                        2'd1:    pend_y <= acc;
                        2'd2:    pend_z <= acc;
                        default: pend_x <= acc;
                    endcase
                    if (channel != 2'd2)
                        channel <= channel + 2'd1;
                end
                PUBLISH: begin
                    x_bcd     <= pend_x;
                    y_bcd     <= pend_y;
                    z_bcd     <= pend_z;
                    sat       <= pend_sat;
                    done      <= 1'b1;
                    bcd_valid <= 1'b1;
                    channel   <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coord_bcd_scheduler.sv
// Scoreboard bench: a clamping and a modulo instance share stimulus; a negedge
// monitor compares both against a decimal-arithmetic model on every cycle.
module tb_coord_bcd_scheduler;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0;
    logic [9:0]       x_coord = '0, y_coord = '0, z_coord = '0;
    logic [1:0][11:0] xb, yb, zb;
    logic [1:0][2:0]  sat;
    logic [1:0]       done, valid, busy, ovr;

    always #5 clk = ~clk;

    coord_bcd_scheduler #(.CLAMP(1'b1)) u_clamp (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x_coord(x_coord), .y_coord(y_coord), .z_coord(z_coord),
        .x_bcd(xb[0]), .y_bcd(yb[0]), .z_bcd(zb[0]), .sat(sat[0]),
        .done(done[0]), .bcd_valid(valid[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    coord_bcd_scheduler #(.CLAMP(1'b0)) u_mod (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x_coord(x_coord), .y_coord(y_coord), .z_coord(z_coord),
        .x_bcd(xb[1]), .y_bcd(yb[1]), .z_bcd(zb[1]), .sat(sat[1]),
        .done(done[1]), .bcd_valid(valid[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    typedef struct {
        int     x, y, z;
        longint e0;
    } rec_t;

    rec_t        sb[$];
    longint      cyc = 0;
    longint      next_ok = 0;
    longint      last_e0 = 0;
    logic [38:0] last_pub[2];
    logic        valid_exp = 1'b0;
    logic        ovr_exp = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;
    int          busy_cnt[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fix(int v, bit clamp);
        if (v < 1000) return v;
        return clamp ? 999 : v - 1000;
    endfunction

    function automatic logic [11:0] dec(int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    endtask

    // The monitor owns the published-value model: it retires scoreboard entries
    // exactly 37 edges after their accepting edge and checks outputs every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt[0] = 0;
            busy_cnt[1] = 0;
        end else begin
            bit exp_done;
            exp_done = (sb.size() > 0) && (sb[0].e0 + 37 == cyc);
            if (exp_done) begin
                rec_t r;
                r = sb.pop_front();
                for (int d = 0; d < 2; d++)
                    last_pub[d] = {dec(fix(r.x, d == 0)), dec(fix(r.y, d == 0)), dec(fix(r.z, d == 0)),
                                   r.z > 999, r.y > 999, r.x > 999};
                valid_exp = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                if (exp_done || done[d])
                    chk("done", d, 64'(done[d]), 64'(exp_done));
                chk("outputs", d, 64'({xb[d], yb[d], zb[d], sat[d], valid[d]}),
                    64'({last_pub[d], valid_exp}));
                if (busy[d]) busy_cnt[d]++;
                else if (busy_cnt[d] != 0) begin
                    chk("busy_len", d, 64'(busy_cnt[d]), 64'd37);
                    busy_cnt[d] = 0;
                end
            end
        end
    end

    task automatic wait_cycles(int n, bit churn);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (churn) begin
                x_coord = 10'($urandom_range(1023));
                y_coord = 10'($urandom_range(1023));
                z_coord = 10'($urandom_range(1023));
            end
        end
    endtask

    task automatic issue(int x, int y, int z);
        longint e;
        x_coord = 10'(x);
        y_coord = 10'(y);
        z_coord = 10'(z);
        frame_start = 1'b1;
        e = cyc + 1;
        if (e >= next_ok) begin
            sb.push_back('{x: x, y: y, z: z, e0: e});
            next_ok = e + 38;
            last_e0 = e;
        end else begin
            ovr_exp = 1'b1;
        end
        wait_cycles(1, 0);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(bit churn);
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            wait_cycles(1, churn);
            n++;
        end
        if (sb.size() > 0) begin
            chk("idle_timeout", 0, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        last_pub[0] = '0;
        last_pub[1] = '0;
        valid_exp = 1'b0;
        ovr_exp = 1'b0;
        next_ok = 0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 2; d++)
            chk("reset_state", d, 64'({xb[d], yb[d], zb[d], sat[d], done[d], valid[d], busy[d], ovr[d]}), 64'd0);
    endtask

    task automatic check_overrun();
        for (int d = 0; d < 2; d++)
            chk("overrun", d, 64'(ovr[d]), 64'(ovr_exp));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_reset();
        check_reset_state();

        issue(123, 456, 789);
        wait_idle(1);
        issue(0, 999, 1023);
        wait_idle(1);
        check_overrun();

        // Snapshot isolation: x changes after the accepting edge.
        issue(500, 1, 2);
        wait_cycles(4, 0);
        x_coord = 10'd77;
        wait_idle(0);
        issue(77, 1, 2);
        wait_idle(0);

        // Collision mid-pass, then collision on the publish edge itself.
        issue(1, 2, 3);
        wait_cycles(8, 0);
        issue(4, 5, 6);
        wait_idle(0);
        check_overrun();
        issue(7, 8, 9);
        while (cyc < last_e0 + 36) wait_cycles(1, 0);
        issue(10, 11, 12);
        wait_idle(0);
        wait_cycles(5, 0);
        check_overrun();
        issue(13, 14, 15);
        wait_idle(0);
        check_overrun();

        // Reset mid-pass aborts without a publish.
        issue(11, 22, 33);
        wait_cycles(18, 0);
        apply_reset();
        check_reset_state();
        wait_cycles(40, 0);
        issue(42, 0, 0);
        wait_idle(0);

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(1023)), int'($urandom_range(1023)), int'($urandom_range(1023)));
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(15) == 0)
                    issue(int'($urandom_range(1023)), int'($urandom_range(1023)), int'($urandom_range(1023)));
                else
                    wait_cycles(1, 1);
            end
            wait_idle(1);
            wait_cycles(int'($urandom_range(3)), 0);
        end
        check_overrun();

        for (int v = 0; v < 1024; v++) begin
            issue(v, (v + 341) % 1024, (v + 682) % 1024);
            wait_idle(0);
        end
        check_overrun();

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
